// File: rtl/program_loader_pkg.sv
// Shared definitions for the instruction-RAM loader: loader state encoding and word width.
package program_loader_pkg;

  localparam int WORD_W = 16;

  typedef enum logic [3:0] {
    LD_IDLE    = 4'd0,
    LD_LEN_HI  = 4'd1,
    LD_LEN_LO  = 4'd2,
    LD_DATA_HI = 4'd3,
    LD_DATA_LO = 4'd4,
    LD_WRITE   = 4'd5,
    LD_CHK_HI  = 4'd6,
    LD_CHK_LO  = 4'd7,
    LD_DONE    = 4'd8,
    LD_ERROR   = 4'd9
  } ld_state_e;

endpackage

// File: rtl/program_loader.sv
// Byte-stream program loader: packs big-endian words into RAM port A and holds the CPU until done.
// Optional trailing checksum word is enabled by defining LOADER_CHECKSUM_EN.
//
// Byte handshake: a byte transfers on a rising clk edge where byte_valid & byte_ready are both 1;
// byte_ready depends only on state, never on byte_valid.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [WORD_W-1:0] ram_data,
  output logic              ram_we,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [15:0]       words_loaded,
  output ld_state_e         state_dbg
);

  localparam logic [16:0]       DEPTH = 17'(2 ** ADDR_W);
  localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(BASE_ADDR);

  ld_state_e   state, next_state;
  logic [7:0]  hi_q;
  logic [15:0] len_q;
  logic [15:0] pair_word;
  logic [15:0] wl_inc;
  logic        accept;
  logic        restart;
`ifdef LOADER_CHECKSUM_EN
  logic [15:0] sum_q;
  logic [15:0] chk_total;
`endif

  assign pair_word = {hi_q, byte_in};
  assign wl_inc    = words_loaded + 16'd1;
  assign accept    = byte_valid & byte_ready;
  assign restart   = start & ((state == LD_IDLE) | (state == LD_DONE) | (state == LD_ERROR));
`ifdef LOADER_CHECKSUM_EN
  assign chk_total = sum_q + pair_word;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= LD_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      LD_IDLE, LD_DONE, LD_ERROR: if (start) next_state = LD_LEN_HI;
      LD_LEN_HI:  if (accept) next_state = LD_LEN_LO;
      LD_LEN_LO: begin
        if (accept) begin
          if ({1'b0, pair_word} > DEPTH) next_state = LD_ERROR;
          else if (pair_word == 16'd0)   next_state = LD_DONE;
          else                           next_state = LD_DATA_HI;
        end
      end
      LD_DATA_HI: if (accept) next_state = LD_DATA_LO;
      LD_DATA_LO: if (accept) next_state = LD_WRITE;
      LD_WRITE: begin
        if (wl_inc < len_q) next_state = LD_DATA_HI;
`ifdef LOADER_CHECKSUM_EN
        else                next_state = LD_CHK_HI;
`else
        else                next_state = LD_DONE;
`endif
      end
`ifdef LOADER_CHECKSUM_EN
      LD_CHK_HI: if (accept) next_state = LD_CHK_LO;
      LD_CHK_LO: if (accept) next_state = (chk_total == 16'h0000) ? LD_DONE : LD_ERROR;
`endif
      default: next_state = LD_IDLE;
    endcase
  end

  always_comb begin
    byte_ready = 1'b0;
    case (state)
      LD_LEN_HI, LD_LEN_LO, LD_DATA_HI, LD_DATA_LO, LD_CHK_HI, LD_CHK_LO: byte_ready = 1'b1;
      default: byte_ready = 1'b0;
    endcase
  end

  // done/error/cpu_hold are pure state decodes, so they can never disagree.
  assign ram_we    = (state == LD_WRITE);
  assign done      = (state == LD_DONE);
  assign error     = (state == LD_ERROR);
  assign cpu_hold  = (state != LD_DONE);
  assign state_dbg = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_q         <= 8'd0;
      len_q        <= 16'd0;
      ram_addr     <= BASE;
      ram_data     <= '0;
      words_loaded <= 16'd0;
`ifdef LOADER_CHECKSUM_EN
      sum_q        <= 16'd0;
`endif
    end else begin
      if (restart) begin
        ram_addr     <= BASE;
        words_loaded <= 16'd0;
`ifdef LOADER_CHECKSUM_EN
        sum_q        <= 16'd0;
`endif
      end
      if (accept) hi_q <= byte_in;
      if (accept && state == LD_LEN_LO)  len_q    <= pair_word;
      if (accept && state == LD_DATA_LO) ram_data <= pair_word;
      // Address/count advance on the edge that ends the write strobe; ram_addr wraps mod DEPTH.
      if (state == LD_WRITE) begin
        ram_addr     <= ram_addr + 1'b1;
        words_loaded <= wl_inc;
`ifdef LOADER_CHECKSUM_EN
        sum_q        <= sum_q + ram_data;
`endif
      end
    end
  end

endmodule
